// File: rtl/fft_stage_agu_if.sv
// Memory/butterfly side of the FFT address-generation unit: bank select,
// read/write addresses, twiddle index and their qualifying strobes.
interface fft_stage_agu_if #(
    parameter int LOG2N = 5
) ();
    // No back-pressure: rd_valid qualifies addr_1/addr_2/tw_idx in the same
    // cycle and write_enable qualifies addw_1/addw_2; the slave always accepts.
    logic             select;
    logic             write_enable;
    logic             rd_valid;
    logic [LOG2N-1:0] addr_1;
    logic [LOG2N-1:0] addr_2;
    logic [LOG2N-1:0] addw_1;
    logic [LOG2N-1:0] addw_2;
    logic [LOG2N-2:0] tw_idx;

    modport master (
        output select, write_enable, rd_valid,
        output addr_1, addr_2, addw_1, addw_2, tw_idx
    );

    modport slave (
        input select, write_enable, rd_valid,
        input addr_1, addr_2, addw_1, addw_2, tw_idx
    );
endinterface

// File: rtl/fft_stage_agu.sv
// Radix-2 DIT FFT stage sequencer: walks all LOG2N stages in place across a
// ping-pong bank pair, issuing butterfly reads and delayed matching writes.
module fft_stage_agu #(
    parameter int LOG2N  = 5,
    parameter int BF_LAT = 3,
    localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          src_bank,
    output logic          busy,
    output logic          done,
    output logic          result_bank,
    output logic [SW-1:0] stage,
    output logic [1:0]    stateDbg,
    fft_stage_agu_if.master mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int CW = 4;
    localparam logic [LOG2N-2:0] LAST_J     = '1;
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [CW-1:0]    LAST_CNT   = CW'(BF_LAT - 1);
    localparam logic             ODD_STAGES = 1'(LOG2N % 2);

    state_t            state, nextState;
    logic [LOG2N-2:0]  jQ, jNext;
    logic [SW-1:0]     stageQ, stageNext;
    logic [CW-1:0]     cntQ, cntNext;
    logic              loadStart, toggleSel;

    logic              selQ, srcQ, busyQ, doneQ, resultQ, rdValidQ;
    logic [LOG2N-1:0]  addr1Q, addr2Q;
    logic [LOG2N-2:0]  twQ;
    logic [LOG2N-1:0]  aNext, bNext;
    logic [LOG2N-2:0]  twNext;

    logic              pipeV [BF_LAT];
    logic [LOG2N-1:0]  pipeA [BF_LAT];
    logic [LOG2N-1:0]  pipeB [BF_LAT];

    // Upper-leg index: j with a zero spliced in at bit position s.
    function automatic logic [LOG2N-1:0] insertZero(input logic [LOG2N-2:0] jv,
                                                    input logic [SW-1:0] s);
        logic [LOG2N-1:0] jx;
        logic [LOG2N-1:0] lowMask;
        jx      = {1'b0, jv};
        lowMask = (LOG2N'(1) << s) - LOG2N'(1);
        return ((((jx >> s) << s) << 1) | (jx & lowMask));
    endfunction

    function automatic logic [LOG2N-2:0] twiddle(input logic [LOG2N-2:0] jv,
                                                 input logic [SW-1:0] s);
        logic [LOG2N-2:0] lowMask;
        lowMask = (LOG2N-1)'((LOG2N'(1) << s) - LOG2N'(1));
        return (jv & lowMask) << (LOG2N - 1 - int'(s));
    endfunction

    assign aNext  = insertZero(jNext, stageNext);
    assign bNext  = aNext | (LOG2N'(1) << stageNext);
    assign twNext = twiddle(jNext, stageNext);

    always_comb begin
        nextState = state;
        jNext     = jQ;
        stageNext = stageQ;
        cntNext   = cntQ;
        loadStart = 1'b0;
        toggleSel = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    loadStart = 1'b1;
                    nextState = ISSUE;
                    jNext     = '0;
                    stageNext = '0;
                end
            end
            ISSUE: begin
                if (jQ == LAST_J) begin
                    nextState = DRAIN;
                    cntNext   = '0;
                end else begin
                    jNext = jQ + 1'b1;
                end
            end
            DRAIN: begin
                // Bank select may only flip once every write of the stage has landed.
                if (cntQ == LAST_CNT) begin
                    if (stageQ != LAST_STAGE) begin
                        nextState = ISSUE;
                        stageNext = stageQ + 1'b1;
                        jNext     = '0;
                        toggleSel = 1'b1;
                    end else begin
                        nextState = FIN;
                    end
                end else begin
                    cntNext = cntQ + 1'b1;
                end
            end
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            jQ       <= '0;
            stageQ   <= '0;
            cntQ     <= '0;
            selQ     <= 1'b0;
            srcQ     <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            resultQ  <= 1'b0;
            rdValidQ <= 1'b0;
            addr1Q   <= '0;
            addr2Q   <= '0;
            twQ      <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                pipeV[i] <= 1'b0;
                pipeA[i] <= '0;
                pipeB[i] <= '0;
            end
        end else begin
            state  <= nextState;
            jQ     <= jNext;
            stageQ <= stageNext;
            cntQ   <= cntNext;
            if (loadStart) begin
                srcQ <= src_bank;
                selQ <= src_bank;
            end else if (toggleSel) begin
                selQ <= ~selQ;
            end
            busyQ    <= (nextState != IDLE);
            doneQ    <= (nextState == FIN);
            rdValidQ <= (nextState == ISSUE);
            if (nextState == FIN) begin
                resultQ <= srcQ ^ ODD_STAGES;
            end
            if (nextState == ISSUE) begin
                addr1Q <= aNext;
                addr2Q <= bNext;
                twQ    <= twNext;
            end
            pipeV[0] <= rdValidQ;
            pipeA[0] <= addr1Q;
            pipeB[0] <= addr2Q;
            for (int i = 1; i < BF_LAT; i++) begin
                pipeV[i] <= pipeV[i-1];
                pipeA[i] <= pipeA[i-1];
                pipeB[i] <= pipeB[i-1];
            end
        end
    end

    assign busy        = busyQ;
    assign done        = doneQ;
    assign result_bank = resultQ;
    assign stage       = stageQ;
    assign stateDbg    = state;

    assign mem.select       = selQ;
    assign mem.rd_valid     = rdValidQ;
    assign mem.addr_1       = addr1Q;
    assign mem.addr_2       = addr2Q;
    assign mem.tw_idx       = twQ;
    assign mem.write_enable = pipeV[BF_LAT-1];
    assign mem.addw_1       = pipeA[BF_LAT-1];
    assign mem.addw_2       = pipeB[BF_LAT-1];

endmodule

// File: tb/tb_fft_stage_agu.sv
// Bench for fft_stage_agu: cycle-exact control timing, scoreboarded read/write
// address streams, and an identity transform through a ping-pong memory model.
module tb_fft_stage_agu;

    localparam int LOG2N  = 5;
    localparam int BF_LAT = 3;
    localparam int N      = 1 << LOG2N;
    localparam int HALF   = N / 2;
    localparam int PERIOD = HALF + BF_LAT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       srcBank;
    logic       busy, done, resultBank;
    logic [2:0] stage;
    logic [1:0] stateDbg;

    int nAsserts = 0;
    int nFails   = 0;

    logic [13:0] rdExpQ[$];
    logic [9:0]  wrExpQ[$];
    logic [13:0] rdExp;
    logic [9:0]  wrExp;

    logic [15:0] bankA [N];
    logic [15:0] bankB [N];
    logic [15:0] refData [N];
    logic [15:0] d1a, d1b, d2a, d2b, d3a, d3b;

    fft_stage_agu_if #(.LOG2N(LOG2N)) memIf ();

    fft_stage_agu #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_bank    (srcBank),
        .busy        (busy),
        .done        (done),
        .result_bank (resultBank),
        .stage       (stage),
        .stateDbg    (stateDbg),
        .mem         (memIf)
    );

    always #5 clk = ~clk;

    // Ping-pong memory with 1-cycle read and a 2-cycle passthrough butterfly.
    always @(posedge clk) begin
        d1a <= memIf.select ? bankB[memIf.addr_1] : bankA[memIf.addr_1];
        d1b <= memIf.select ? bankB[memIf.addr_2] : bankA[memIf.addr_2];
        d2a <= d1a;
        d2b <= d1b;
        d3a <= d2a;
        d3b <= d2b;
        if (memIf.write_enable) begin
            if (memIf.select) begin
                bankA[memIf.addw_1] <= d3a;
                bankA[memIf.addw_2] <= d3b;
            end else begin
                bankB[memIf.addw_1] <= d3a;
                bankB[memIf.addw_2] <= d3b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: every live read and write must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (memIf.rd_valid) begin
                check("rd_queue_nonempty", 32'(rdExpQ.size() != 0), 32'd1);
                if (rdExpQ.size() != 0) begin
                    rdExp = rdExpQ.pop_front();
                    check("rd_addr_tw", 32'({memIf.addr_1, memIf.addr_2, memIf.tw_idx}),
                          32'(rdExp));
                end
            end
            if (memIf.write_enable) begin
                check("wr_queue_nonempty", 32'(wrExpQ.size() != 0), 32'd1);
                if (wrExpQ.size() != 0) begin
                    wrExp = wrExpQ.pop_front();
                    check("wr_addr", 32'({memIf.addw_1, memIf.addw_2}), 32'(wrExp));
                end
            end
        end
    end

    task automatic launch(input logic src);
        start   = 1'b1;
        srcBank = src;
        for (int i = 0; i < N; i++) begin
            refData[i] = 16'($urandom_range(0, 65535));
            if (src) bankB[i] <= refData[i];
            else     bankA[i] <= refData[i];
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int j = 0; j < HALF; j++) begin
                int lo, hi, a, b, tw;
                lo = j % (1 << s);
                hi = j / (1 << s);
                a  = hi * (2 << s) + lo;
                b  = a + (1 << s);
                tw = lo * (1 << (LOG2N - 1 - s));
                rdExpQ.push_back({5'(a), 5'(b), 4'(tw)});
                wrExpQ.push_back({5'(a), 5'(b)});
            end
        end
    endtask

    task automatic runChecks(input logic src, input bit chain, input logic nextSrc);
        for (int k = 1; k <= LOG2N * PERIOD + 2; k++) begin
            int  stg;
            bit  inIssue, inWrite;
            @(negedge clk);
            if (chain && k == LOG2N * PERIOD + 2) launch(nextSrc);
            else start = (k == 40 || k == LOG2N * PERIOD + 1);
            stg = (k - 1) / PERIOD;
            if (stg > LOG2N - 1) stg = LOG2N - 1;
            inIssue = (k <= LOG2N * PERIOD) && (((k - 1) % PERIOD) < HALF);
            inWrite = (k > BF_LAT) && (k <= LOG2N * PERIOD) &&
                      (((k - 1 - BF_LAT) % PERIOD) < HALF);
            check("rd_valid", 32'(memIf.rd_valid), 32'(inIssue));
            check("write_enable", 32'(memIf.write_enable), 32'(inWrite));
            check("done", 32'(done), 32'(k == LOG2N * PERIOD + 1));
            check("busy", 32'(busy), 32'(k <= LOG2N * PERIOD + 1));
            check("stage", 32'(stage), 32'(stg));
            check("select", 32'(memIf.select), 32'(src ^ stg[0]));
            if (k == 1) begin
                check("first_addr_1", 32'(memIf.addr_1), 32'd0);
                check("first_addr_2", 32'(memIf.addr_2), 32'd1);
                check("first_tw", 32'(memIf.tw_idx), 32'd0);
            end
            if (k == 2 * PERIOD + 1 + 5) begin
                check("s2j5_addr_1", 32'(memIf.addr_1), 32'd9);
                check("s2j5_addr_2", 32'(memIf.addr_2), 32'd13);
                check("s2j5_tw", 32'(memIf.tw_idx), 32'd4);
            end
            if (k == 4 * PERIOD + 1 + 3) begin
                check("s4j3_addr_1", 32'(memIf.addr_1), 32'd3);
                check("s4j3_addr_2", 32'(memIf.addr_2), 32'd19);
                check("s4j3_tw", 32'(memIf.tw_idx), 32'd3);
            end
            if (k >= LOG2N * PERIOD + 1) begin
                check("result_bank", 32'(resultBank), 32'(src ^ 1'b1));
            end
            if (k == LOG2N * PERIOD + 1) begin
                for (int i = 0; i < N; i++) begin
                    check("result_data", 32'(src ? bankA[i] : bankB[i]), 32'(refData[i]));
                end
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        srcBank = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_select", 32'(memIf.select), 32'd0);
        check("rst_result_bank", 32'(resultBank), 32'd0);
        check("rst_state", 32'(stateDbg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Run 1 from bank A, back-to-back with run 2 from bank B.
        launch(1'b0);
        runChecks(1'b0, 1'b1, 1'b1);
        runChecks(1'b1, 1'b0, 1'b0);
        check("rd_queue_drained", 32'(rdExpQ.size()), 32'd0);
        check("wr_queue_drained", 32'(wrExpQ.size()), 32'd0);

        // Run 3 aborted by asynchronous reset mid-ISSUE of stage 2.
        @(negedge clk);
        launch(1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * PERIOD + 5) @(negedge clk);
        check("pre_abort_rd_valid", 32'(memIf.rd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result_bank", 32'(resultBank), 32'd0);
        check("abort_stage", 32'(stage), 32'd0);
        check("abort_state", 32'(stateDbg), 32'd0);
        check("abort_select", 32'(memIf.select), 32'd0);
        check("abort_rd_valid", 32'(memIf.rd_valid), 32'd0);
        check("abort_write_enable", 32'(memIf.write_enable), 32'd0);
        check("abort_addr", 32'({memIf.addr_1, memIf.addr_2, memIf.tw_idx}), 32'd0);
        check("abort_addw", 32'({memIf.addw_1, memIf.addw_2}), 32'd0);
        rdExpQ.delete();
        wrExpQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_abort_write_enable", 32'(memIf.write_enable), 32'd0);
            check("post_abort_state", 32'(stateDbg), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
